key_encoder: RTL

KEY_ENCODER -- requirements
Module: key_encoder

---
 rtl/key_encoder_pkg.sv | 31 +++
 rtl/key_sync.sv | 24 ++
 rtl/key_encoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/key_encoder_pkg.sv
// Shared types and helpers for the key_encoder block: state enum, key width,
// default debounce length and the 8-to-3 priority encoder.
package key_encoder_pkg;

    localparam int KEY_W             = 8;
    localparam int STABLE_CYCLES_DEF = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0] y;
        logic       valid;
    } enc_t;

    // Ascending scan: the last set bit seen is the most significant one.
    function automatic enc_t prio_enc(input logic [KEY_W-1:0] v);
        enc_t r;
        r = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (v[i]) begin
                r.y     = 3'(i);
                r.valid = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous key vector, cleared by rst.
module key_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // NOTE: non-blocking assignments keep the two stages a true shift; blocking would collapse them into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_encoder.sv
// Debounced priority encoder for an 8-bit key vector. Debouncing FSM is built
// only when KEY_ENCODER_DEBOUNCE_EN is defined; otherwise xs commits every edge.
module key_encoder
    import key_encoder_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] x,
    input  logic             en,
    output logic [2:0]       y,
    output logic             valid,
    output logic             upd
);

    if (STABLE_CYCLES < 2) begin : g_bad_param
        $error("key_encoder: STABLE_CYCLES must be at least 2");
    end

    logic [KEY_W-1:0] xs;
    logic [KEY_W-1:0] comm;
    enc_t             enc_next;

    key_sync #(.W(KEY_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (x),
        .q   (xs)
    );

`ifdef KEY_ENCODER_DEBOUNCE_EN
    localparam int                CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    logic [KEY_W-1:0] cand;
    logic [CNT_W-1:0] cnt;

    assign enc_next = prio_enc(cand);

    // y/valid always equal prio_enc(comm), so comparing against the old comm
    // tells whether this commit is visible on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
            comm  <= '0;
            y     <= '0;
            valid <= 1'b0;
            upd   <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (xs != comm) begin
                            cand  <= xs;
                            cnt   <= '0;
                            state <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (xs != cand) begin
                            cand <= xs;
                            cnt  <= '0;
                        end else if (cnt != CNT_LAST) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            comm  <= cand;
                            y     <= enc_next.y;
                            valid <= enc_next.valid;
                            upd   <= (enc_next != prio_enc(comm));
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`else
    assign enc_next = prio_enc(xs);

    always_ff @(posedge clk) begin
        if (rst) begin
            comm  <= '0;
            y     <= '0;
            valid <= 1'b0;
            upd   <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (en) begin
                comm  <= xs;
                y     <= enc_next.y;
                valid <= enc_next.valid;
                upd   <= (enc_next != prio_enc(comm));
            end
        end
    end
`endif

endmodule
